// File: rtl/mem_access_ctrl.sv
// Byte-serial load/store sequencer between a RISC-V load/store unit and a
// byte-wide, single-cycle-latency synchronous memory array. One 8/16/32-bit
// access (selected by funct3) is run as 1-4 consecutive byte cycles with
// little-endian byte order; loads are sign- or zero-extended on completion.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [7:0]            mem_write_data,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [7:0]            mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [1:0]            r_k;
    logic [1:0]            r_last;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rbuf;

    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [31:0]           r_resp_rdata;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_waddr;
    logic [7:0]            r_mem_wdata;
    logic                  r_mem_re;
    logic [ADDR_WIDTH-1:0] r_mem_raddr;

    logic [1:0]            w_next_k;
    logic [1:0]            w_capture_idx;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [31:0]           w_rbuf_full;
    logic                  w_unused_addr;

    // Index of the last byte of the access (access size minus one)
    function automatic logic [1:0] f_last_idx(input logic [2:0] f3);
        case (f3)
            3'd1, 3'd5: f_last_idx = 2'd1;
            3'd2:       f_last_idx = 2'd3;
            default:    f_last_idx = 2'd0;
        endcase
    endfunction

    // Stores only exist as SB/SH/SW; loads add LBU/LHU
    function automatic logic f_legal(input logic we, input logic [2:0] f3);
        if (we) f_legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    f_legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                          (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    // Sign or zero extension of the assembled load bytes
    function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    f_extend = {{24{d[7]}}, d[7:0]};
            3'd1:    f_extend = {{16{d[15]}}, d[15:0]};
            3'd2:    f_extend = d;
            3'd4:    f_extend = {24'd0, d[7:0]};
            3'd5:    f_extend = {16'd0, d[15:0]};
            default: f_extend = 32'd0;
        endcase
    endfunction

    assign w_next_k      = r_k + 2'd1;
    assign w_capture_idx = r_k - 2'd1;
    assign w_next_addr   = r_addr + ADDR_WIDTH'(w_next_k);
    assign w_req_addr    = req_addr[ADDR_WIDTH-1:0];
    // Upper address bits lie outside the array and are intentionally ignored
    assign w_unused_addr = ^req_addr[31:ADDR_WIDTH];

    // Load buffer with the final byte (arriving during WAIT) merged in
    always_comb begin
        w_rbuf_full = r_rbuf;
        w_rbuf_full[{r_k, 3'b000} +: 8] = mem_read_data;
    end

    // Sequencer FSM; all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_k          <= 2'd0;
            r_last       <= 2'd0;
            r_funct3     <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_rbuf       <= 32'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_mem_we     <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= 8'd0;
            r_mem_re     <= 1'b0;
            r_mem_raddr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_funct3    <= req_funct3;
                        r_addr      <= w_req_addr;
                        r_wdata     <= req_wdata;
                        r_k         <= 2'd0;
                        r_last      <= f_last_idx(req_funct3);
                        r_rbuf      <= 32'd0;
                        r_req_ready <= 1'b0;
                        if (!f_legal(req_we, req_funct3)) begin
                            // Illegal size: respond immediately, never touch memory
                            r_state      <= S_DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                        end else if (req_we) begin
                            r_state     <= S_WRITE;
                            r_mem_we    <= 1'b1;
                            r_mem_waddr <= w_req_addr;
                            r_mem_wdata <= req_wdata[7:0];
                        end else begin
                            r_state     <= S_READ;
                            r_mem_re    <= 1'b1;
                            r_mem_raddr <= w_req_addr;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_k == r_last) begin
                        r_state      <= S_DONE;
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'd0;
                    end else begin
                        r_k         <= w_next_k;
                        r_mem_waddr <= w_next_addr;
                        r_mem_wdata <= r_wdata[{w_next_k, 3'b000} +: 8];
                    end
                end
                S_READ: begin
                    // Read data lags the enable by one cycle: byte k-1 arrives now
                    if (r_k != 2'd0) begin
                        r_rbuf[{w_capture_idx, 3'b000} +: 8] <= mem_read_data;
                    end
                    if (r_k == r_last) begin
                        r_state  <= S_WAIT;
                        r_mem_re <= 1'b0;
                    end else begin
                        r_k         <= w_next_k;
                        r_mem_raddr <= w_next_addr;
                    end
                end
                S_WAIT: begin
                    r_rbuf       <= w_rbuf_full;
                    r_state      <= S_DONE;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= f_extend(r_funct3, w_rbuf_full);
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'd0;
                    r_req_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_we    <= 1'b0;
                    r_mem_re    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready         = r_req_ready;
    assign resp_valid        = r_resp_valid;
    assign resp_err          = r_resp_err;
    assign resp_rdata        = r_resp_rdata;
    assign mem_write_enable  = r_mem_we;
    assign mem_write_address = r_mem_waddr;
    assign mem_write_data    = r_mem_wdata;
    assign mem_read_enable   = r_mem_re;
    assign mem_read_address  = r_mem_raddr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a byte-wide memory model,
// a response scoreboard and expected write/read byte streams.
module tb_mem_access_ctrl;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_write_enable;
    logic [AW-1:0] mem_write_address;
    logic [7:0]    mem_write_data;
    logic          mem_read_enable;
    logic [AW-1:0] mem_read_address;
    logic [7:0]    mem_read_data;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_funct3        (req_funct3),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_err          (resp_err),
        .resp_rdata        (resp_rdata),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_read_enable   (mem_read_enable),
        .mem_read_address  (mem_read_address),
        .mem_read_data     (mem_read_data)
    );

    // Attached byte array: one write port, one read port, 1-cycle read latency
    logic [7:0] mem_arr [0:(1<<AW)-1];
    logic [7:0] mem_rd_q = 8'd0;
    always @(posedge clk) begin
        if (mem_write_enable) mem_arr[mem_write_address] <= mem_write_data;
        if (mem_read_enable)  mem_rd_q <= mem_arr[mem_read_address];
    end
    assign mem_read_data = mem_rd_q;

    typedef struct { logic [31:0] rdata; logic err; int lat; } resp_t;
    typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
    typedef struct {
        logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
        logic [31:0] rdata; logic err; int lat;
    } req_t;

    resp_t         exp_q [$];
    wr_t           wr_q  [$];
    logic [AW-1:0] rd_q  [$];

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;

    logic        obs_seen;
    int          obs_lat;
    logic [31:0] obs_rdata;
    logic        obs_err;
    wr_t           mon_w;
    logic [AW-1:0] mon_r;

    // Byte stream monitor: every enabled memory cycle must match the next expected byte
    always @(negedge clk) begin
        if (mem_write_enable) begin
            wr_cnt++;
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL mem_write unexpected: addr=%h data=%h", mem_write_address, mem_write_data);
            end else begin
                mon_w = wr_q.pop_front();
                if (mem_write_address !== mon_w.a || mem_write_data !== mon_w.d) begin
                    failures++;
                    $display("FAIL mem_write: got addr=%h data=%h want addr=%h data=%h",
                             mem_write_address, mem_write_data, mon_w.a, mon_w.d);
                end
            end
        end
        if (mem_read_enable) begin
            rd_cnt++;
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL mem_read unexpected: addr=%h", mem_read_address);
            end else begin
                mon_r = rd_q.pop_front();
                if (mem_read_address !== mon_r) begin
                    failures++;
                    $display("FAIL mem_read: got addr=%h want addr=%h", mem_read_address, mon_r);
                end
            end
        end
    end

    function automatic int nbytes(input logic we, input logic [2:0] f3);
        if (we) begin
            case (f3)
                3'd0: return 1;
                3'd1: return 2;
                3'd2: return 4;
                default: return 0;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2: return 4;
                default: return 0;
            endcase
        end
    endfunction

    // Push expectations for one access (response + byte stream)
    task automatic push_expect(input req_t r);
        resp_t e;
        wr_t w;
        logic [AW-1:0] a;
        e.rdata = r.rdata; e.err = r.err; e.lat = r.lat;
        exp_q.push_back(e);
        for (int k = 0; k < nbytes(r.we, r.f3); k++) begin
            a = r.addr[AW-1:0] + AW'(k);
            if (r.we) begin
                w.a = a;
                w.d = r.wdata[8*k +: 8];
                wr_q.push_back(w);
            end else begin
                rd_q.push_back(a);
            end
        end
    endtask

    // Drive one request, then observe the response (no checking here)
    task automatic issue(input req_t r);
        int n;
        push_expect(r);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_we     = r.we;
        req_funct3 = r.f3;
        req_addr   = r.addr;
        req_wdata  = r.wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        obs_seen = 1'b0; obs_lat = 0; obs_rdata = 32'd0; obs_err = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                obs_seen = 1'b1; obs_lat = i; obs_rdata = resp_rdata; obs_err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h50; req_wdata = 32'h12345678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL reset_priority_we: got %b want 0", mem_write_enable); end
        checks++; if (mem_read_enable !== 1'b0) begin failures++; $display("FAIL reset_re: got %b want 0", mem_read_enable); end
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        req_t  tbl [10];
        resp_t e;
        tbl[0] = '{1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 5};
        tbl[1] = '{1'b0, 3'd2, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 6};
        tbl[2] = '{1'b1, 3'd0, 32'h020, 32'hFFFFFF80, 32'h0,        1'b0, 2};
        tbl[3] = '{1'b0, 3'd0, 32'h020, 32'h0,        32'hFFFFFF80, 1'b0, 3};
        tbl[4] = '{1'b0, 3'd4, 32'h020, 32'h0,        32'h00000080, 1'b0, 3};
        tbl[5] = '{1'b1, 3'd1, 32'h020, 32'hFFFF7F01, 32'h0,        1'b0, 3};
        tbl[6] = '{1'b0, 3'd1, 32'h020, 32'h0,        32'h00007F01, 1'b0, 4};
        tbl[7] = '{1'b1, 3'd1, 32'h031, 32'h00008001, 32'h0,        1'b0, 3};
        tbl[8] = '{1'b0, 3'd1, 32'h031, 32'h0,        32'hFFFF8001, 1'b0, 4};
        tbl[9] = '{1'b0, 3'd5, 32'h031, 32'h0,        32'h00008001, 1'b0, 4};
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i]);
            e = exp_q.pop_front();
            checks++; if (!obs_seen || obs_lat != e.lat) begin failures++; $display("FAIL store_load[%0d] latency: got %0d (seen=%b) want %0d", i, obs_lat, obs_seen, e.lat); end
            checks++; if (obs_rdata !== e.rdata) begin failures++; $display("FAIL store_load[%0d] rdata: got %h want %h", i, obs_rdata, e.rdata); end
            checks++; if (obs_err !== e.err) begin failures++; $display("FAIL store_load[%0d] err: got %b want %b", i, obs_err, e.err); end
        end
    endtask

    task automatic test_wrap();
        req_t  tbl [6];
        resp_t e;
        tbl[0] = '{1'b1, 3'd0, 32'h7FE,       32'h00000011, 32'h0,        1'b0, 2};
        tbl[1] = '{1'b1, 3'd1, 32'h7FF,       32'h0000A55A, 32'h0,        1'b0, 3};
        tbl[2] = '{1'b1, 3'd0, 32'h001,       32'h00000022, 32'h0,        1'b0, 2};
        tbl[3] = '{1'b0, 3'd5, 32'hFFFFF7FF,  32'h0,        32'h0000A55A, 1'b0, 4};
        tbl[4] = '{1'b0, 3'd2, 32'h7FE,       32'h0,        32'h22A55A11, 1'b0, 6};
        tbl[5] = '{1'b0, 3'd4, 32'h000,       32'h0,        32'h000000A5, 1'b0, 3};
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i]);
            e = exp_q.pop_front();
            checks++; if (!obs_seen || obs_lat != e.lat) begin failures++; $display("FAIL wrap[%0d] latency: got %0d (seen=%b) want %0d", i, obs_lat, obs_seen, e.lat); end
            checks++; if (obs_rdata !== e.rdata) begin failures++; $display("FAIL wrap[%0d] rdata: got %h want %h", i, obs_rdata, e.rdata); end
            checks++; if (obs_err !== e.err) begin failures++; $display("FAIL wrap[%0d] err: got %b want %b", i, obs_err, e.err); end
        end
    endtask

    task automatic test_illegal();
        req_t  tbl [5];
        resp_t e;
        int    w0, r0;
        tbl[0] = '{1'b0, 3'd3, 32'h010, 32'h0,        32'h0, 1'b1, 1};
        tbl[1] = '{1'b1, 3'd4, 32'h010, 32'hCAFEF00D, 32'h0, 1'b1, 1};
        tbl[2] = '{1'b1, 3'd5, 32'h012, 32'h12345678, 32'h0, 1'b1, 1};
        tbl[3] = '{1'b0, 3'd6, 32'h020, 32'h0,        32'h0, 1'b1, 1};
        tbl[4] = '{1'b0, 3'd7, 32'h020, 32'h0,        32'h0, 1'b1, 1};
        w0 = wr_cnt; r0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            issue(tbl[i]);
            e = exp_q.pop_front();
            checks++; if (!obs_seen || obs_lat != e.lat) begin failures++; $display("FAIL illegal[%0d] latency: got %0d (seen=%b) want %0d", i, obs_lat, obs_seen, e.lat); end
            checks++; if (obs_rdata !== e.rdata) begin failures++; $display("FAIL illegal[%0d] rdata: got %h want %h", i, obs_rdata, e.rdata); end
            checks++; if (obs_err !== e.err) begin failures++; $display("FAIL illegal[%0d] err: got %b want %b", i, obs_err, e.err); end
        end
        repeat (2) @(negedge clk);
        checks++; if (wr_cnt != w0 || rd_cnt != r0) begin failures++; $display("FAIL illegal_mem_enables: got wr=%0d rd=%0d want wr=%0d rd=%0d", wr_cnt, rd_cnt, w0, r0); end
    endtask

    task automatic test_reset_abort();
        req_t  r;
        resp_t e;
        wr_t   w;
        int    stray;
        r = '{1'b1, 3'd2, 32'h040, 32'hCAFEBABE, 32'h0, 1'b0, 5};
        issue(r);
        e = exp_q.pop_front();
        checks++; if (!obs_seen || obs_lat != e.lat) begin failures++; $display("FAIL abort_prefill latency: got %0d want %0d", obs_lat, e.lat); end
        // Only bytes 0 and 1 may reach memory before the reset edge
        w.a = 11'h040; w.d = 8'h44; wr_q.push_back(w);
        w.a = 11'h041; w.d = 8'h33; wr_q.push_back(w);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h040; req_wdata = 32'h11223344;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL abort_cycle1 resp_valid: got %b want 0", resp_valid); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL abort_cycle2 resp_valid: got %b want 0", resp_valid); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b want 1", req_ready); end
        checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL abort_we: got %b want 0", mem_write_enable); end
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) stray++;
            @(negedge clk);
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL abort_no_resp: got %0d pulses want 0", stray); end
        r = '{1'b0, 3'd2, 32'h040, 32'h0, 32'hCAFE3344, 1'b0, 6};
        issue(r);
        e = exp_q.pop_front();
        checks++; if (!obs_seen || obs_lat != e.lat) begin failures++; $display("FAIL abort_readback latency: got %0d want %0d", obs_lat, e.lat); end
        checks++; if (obs_rdata !== e.rdata) begin failures++; $display("FAIL abort_readback rdata: got %h want %h", obs_rdata, e.rdata); end
    endtask

    task automatic test_back_to_back();
        req_t  r1, r2;
        resp_t e;
        int    first_ready, nresp;
        logic  ready7;
        r1 = '{1'b1, 3'd2, 32'h100, 32'h0BADF00D, 32'h0,        1'b0, 5};
        r2 = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h0BADF00D, 1'b0, 12};
        push_expect(r1);
        push_expect(r2);
        @(negedge clk);
        req_we = r1.we; req_funct3 = r1.f3; req_addr = r1.addr; req_wdata = r1.wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_we = r2.we; req_funct3 = r2.f3; req_addr = r2.addr; req_wdata = r2.wdata;
        first_ready = 0; nresp = 0; ready7 = 1'bx;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (req_ready && first_ready == 0) first_ready = n;
            if (n == 7) begin
                ready7 = req_ready;
                req_valid = 1'b0;
            end
            if (resp_valid) begin
                nresp++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b2b extra response at cycle %0d", n);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (n != e.lat) begin failures++; $display("FAIL b2b latency: got %0d want %0d", n, e.lat); end
                    checks++; if (resp_rdata !== e.rdata) begin failures++; $display("FAIL b2b rdata: got %h want %h", resp_rdata, e.rdata); end
                    checks++; if (resp_err !== e.err) begin failures++; $display("FAIL b2b err: got %b want %b", resp_err, e.err); end
                end
            end
        end
        req_valid = 1'b0;
        checks++; if (first_ready != 6) begin failures++; $display("FAIL b2b first_ready_cycle: got %0d want 6", first_ready); end
        checks++; if (ready7 !== 1'b0) begin failures++; $display("FAIL b2b second_accept ready: got %b want 0", ready7); end
        checks++; if (nresp != 2) begin failures++; $display("FAIL b2b response_count: got %0d want 2", nresp); end
    endtask

    task automatic test_drain();
        checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got wr=%0d rd=%0d resp=%0d pending want 0", wr_q.size(), rd_q.size(), exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = 8'd0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        test_reset();
        test_store_load();
        test_wrap();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Byte-serial load/store sequencer that sits between the RISC-V core's load/store unit and one byte-wide, single-cycle-latency synchronous memory array (1 read port, 1 write port, 2^ADDR_WIDTH bytes). It accepts one 8/16/32-bit access at a time, encoded by RISC-V funct3, and runs it as 1-4 sequential byte cycles. Loads are assembled little-endian with sign or zero extension; stores are split little-endian. Completion is signalled with a one-cycle response pulse.

Parameters:
ADDR_WIDTH, 11, byte-address width of the attached array (depth 2^ADDR_WIDTH = 2048)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  1  access request
req_ready  output  1  high when block can accept (IDLE only)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 access size/sign
req_addr  input  32  byte address; only [ADDR_WIDTH-1:0] used
req_wdata  input  32  store data, byte 0 = [7:0]
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  valid with resp_valid; illegal funct3
resp_rdata  output  32  load result, valid with resp_valid
mem_write_enable  output  1  to array write port
mem_write_address  output  ADDR_WIDTH  to array write port
mem_write_data  output  8  to array write port
mem_read_enable  output  1  to array read port
mem_read_address  output  ADDR_WIDTH  to array read port
mem_read_data  input  8  array read data, valid 1 cycle after read enable

Behaviour:
- States: IDLE, WRITE, READ, WAIT, DONE. req_ready = (state==IDLE). Accept = req_valid & req_ready at a posedge; latch we, funct3, addr, wdata; byte counter k=0.
- Size N: funct3 0/4 -> 1, 1/5 -> 2, 2 -> 4. Legal loads: 0,1,2,4,5. Legal stores: 0,1,2. Anything else -> DONE directly with resp_err=1, resp_rdata=0, no memory enables ever asserted.
- Byte address = (addr + k) mod 2^ADDR_WIDTH. Misaligned allowed, wraps at top of array.
- WRITE: N cycles; each cycle mem_write_enable=1, data = wdata[8k+7:8k]; after k=N-1 -> DONE.
- READ: N cycles with mem_read_enable=1 at byte k. In READ cycles with k>=1 capture mem_read_data into byte k-1. After k=N-1 -> WAIT; WAIT captures byte N-1, then -> DONE.
- DONE: resp_valid=1 for exactly one cycle, resp_rdata = assembled bytes; LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; stores return resp_rdata=0. Then -> IDLE.
- Latency (accept edge = cycle 0): store N bytes -> resp_valid in cycle N+1; load N bytes -> cycle N+2. SW: 5, LW: 6, LB: 3, invalid: 1.
- Enables are 0 outside WRITE/READ; addresses/data don't-care when enable low but driven from registered state (no X).
- No back-pressure on response; no new request accepted in DONE. req_valid while busy is ignored, not queued.
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, both mem enables 0. Reset during WRITE aborts: bytes already written stay written, no resp_valid. Reset during READ/WAIT aborts with no response.
- Reset has priority over accept in the same cycle.

Test Plan:
- SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> write bytes EF,BE,AD,DE to 0x010-0x013 over cycles 1-4, store resp cycle 5; load resp cycle 6 with rdata 0xDEADBEEF, err=0.
- SB 0x80 at 0x020; LB 0x020 -> 0xFFFFFF80; LBU 0x020 -> 0x00000080; LH 0x020 after SH 0x7F01 -> 0x00007F01.
- Wrap: SH 0xA55A at 0x7FF -> byte 0x5A at 0x7FF, 0xA5 at 0x000; LHU 0x7FF -> 0x0000A55A; LW 0x7FE reads 0x7FE,0x7FF,0x000,0x001 in order.
- Illegal: load funct3=3, store funct3=4 -> resp_valid cycle 1, resp_err=1, rdata=0, no mem enable ever high.
- Reset asserted in cycle 2 of SW 0x11223344 to 0x040 -> no resp_valid; 0x040=0x44, 0x041=0x33 (if enabled that cycle per timing), 0x042/0x043 unchanged; req_ready=1 cycle after reset.
- Back-to-back: req_valid held high with two different requests -> second accepted only on cycle after first resp_valid; req_ready low throughout first access.
